// File: rtl/imprime_pkg.sv
// Shared state codes, glyph and LED constants for the password-lock front panel driver.
package imprime_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DIGIT2 = 4'd1,
        ST_DIGIT3 = 4'd2,
        ST_DIGIT4 = 4'd3,
        ST_DONE   = 4'd4,
        ST_ERROR  = 4'd5
    } state_e;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned LED_W = 10;
    localparam int unsigned ENTRY_DIGITS = 4;

    typedef logic [SEG_W-1:0] glyph_t;
    typedef logic [LED_W-1:0] leds_t;

    // Active-low, bit order {g,f,e,d,c,b,a}
    localparam glyph_t GLYPH_BLANK = 7'b1111111;
    localparam glyph_t GLYPH_DASH  = 7'b0111111;
    localparam glyph_t GLYPH_UNDER = 7'b1110111;
    localparam glyph_t GLYPH_P     = 7'b0001100;
    localparam glyph_t GLYPH_O     = 7'b1000000;
    localparam glyph_t GLYPH_E     = 7'b0000110;
    localparam glyph_t GLYPH_N     = 7'b0101011;
    localparam glyph_t GLYPH_R     = 7'b0101111;
    localparam glyph_t GLYPH_LO    = 7'b0100011;

    localparam leds_t LEDS_OFF     = '0;
    localparam leds_t LEDS_ALL     = '1;
    localparam leds_t LEDS_BLINK_A = 10'b1010101010;
    localparam leds_t LEDS_BLINK_B = 10'b0101010101;

    // seg4 is the leftmost digit
    typedef struct packed {
        glyph_t seg4;
        glyph_t seg3;
        glyph_t seg2;
        glyph_t seg1;
        glyph_t seg0;
    } panel_t;

    localparam panel_t PANEL_BLANK = '1;

    function automatic leds_t thermo(input int unsigned k);
        leds_t t;
        t = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            if (i < k) t[i] = 1'b1;
        end
        return t;
    endfunction

    // Position 0 is seg3; a position is entered once fewer than k digits precede it
    function automatic glyph_t entry_glyph(input int unsigned pos, input int unsigned k);
        return (pos < k) ? GLYPH_DASH : GLYPH_UNDER;
    endfunction

endpackage

// File: rtl/imprime_blink.sv
// Half-period counter for the error LED blink; phase toggles every BLINK_DIV enabled cycles.
module imprime_blink
    import imprime_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/imprime.sv
// Front-panel driver: decodes the lock FSM state into registered seven-segment and LED-bar outputs.
module imprime
    import imprime_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    output logic [9:0] leds_out,
    output logic [6:0] seg0_out,
    output logic [6:0] seg1_out,
    output logic [6:0] seg2_out,
    output logic [6:0] seg3_out,
    output logic [6:0] seg4_out
);

    logic   in_error;
    logic   blink_phase;
    panel_t panel_q, panel_d;
    leds_t  leds_q, leds_d;

    assign in_error = (state == ST_ERROR);

    imprime_blink #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (in_error),
        .clr  (!in_error),
        .phase(blink_phase)
    );

    always_comb begin
        panel_d = PANEL_BLANK;
        leds_d  = LEDS_OFF;
        case (state)
            ST_IDLE, ST_DIGIT2, ST_DIGIT3, ST_DIGIT4: begin
                panel_d.seg4 = GLYPH_P;
                panel_d.seg3 = entry_glyph(0, 32'(state));
                panel_d.seg2 = entry_glyph(1, 32'(state));
                panel_d.seg1 = entry_glyph(2, 32'(state));
                panel_d.seg0 = entry_glyph(3, 32'(state));
                leds_d       = thermo(32'(state));
            end
            ST_DONE: begin
                panel_d = '{seg4: GLYPH_O, seg3: GLYPH_P, seg2: GLYPH_E,
                            seg1: GLYPH_N, seg0: GLYPH_BLANK};
                leds_d  = LEDS_ALL;
            end
            ST_ERROR: begin
                panel_d = '{seg4: GLYPH_E, seg3: GLYPH_R, seg2: GLYPH_R,
                            seg1: GLYPH_LO, seg0: GLYPH_R};
                leds_d  = blink_phase ? LEDS_BLINK_B : LEDS_BLINK_A;
            end
            default: begin
                panel_d = PANEL_BLANK;
                leds_d  = LEDS_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            panel_q <= PANEL_BLANK;
            leds_q  <= LEDS_OFF;
        end else begin
            panel_q <= panel_d;
            leds_q  <= leds_d;
        end
    end

    assign leds_out = leds_q;
    assign seg4_out = panel_q.seg4;
    assign seg3_out = panel_q.seg3;
    assign seg2_out = panel_q.seg2;
    assign seg1_out = panel_q.seg1;
    assign seg0_out = panel_q.seg0;

endmodule

// File: tb/tb_imprime.sv
// Directed self-checking bench for imprime with a short blink period.
module tb_imprime;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_UNDER = 7'b1110111;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_N     = 7'b0101011;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_LO    = 7'b0100011;

    localparam logic [34:0] P_BLANK = {5{G_BLANK}};
    localparam logic [34:0] P_DONE  = {G_O, G_P, G_E, G_N, G_BLANK};
    localparam logic [34:0] P_ERR   = {G_E, G_R, G_R, G_LO, G_R};
    localparam logic [9:0]  L_A     = 10'b1010101010;
    localparam logic [9:0]  L_B     = 10'b0101010101;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    logic [9:0] leds_out;
    logic [6:0] seg0_out, seg1_out, seg2_out, seg3_out, seg4_out;
    logic [34:0] panel;

    int n_checks = 0;
    int n_fail   = 0;

    assign panel = {seg4_out, seg3_out, seg2_out, seg1_out, seg0_out};

    imprime #(.BLINK_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .leds_out(leds_out),
        .seg0_out(seg0_out),
        .seg1_out(seg1_out),
        .seg2_out(seg2_out),
        .seg3_out(seg3_out),
        .seg4_out(seg4_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        state = 4'd4;
        step();
        step();
        n_checks++;
        if (panel !== P_BLANK) begin
            n_fail++;
            $display("FAIL reset_segs: got %b expected %b", panel, P_BLANK);
        end
        n_checks++;
        if (leds_out !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_leds: got %b expected %b", leds_out, 10'b0);
        end
    endtask

    task automatic test_progress();
        logic [34:0] exp_p [4];
        logic [9:0]  exp_l [4];
        exp_p[0] = {G_P, G_UNDER, G_UNDER, G_UNDER, G_UNDER};
        exp_p[1] = {G_P, G_DASH,  G_UNDER, G_UNDER, G_UNDER};
        exp_p[2] = {G_P, G_DASH,  G_DASH,  G_UNDER, G_UNDER};
        exp_p[3] = {G_P, G_DASH,  G_DASH,  G_DASH,  G_UNDER};
        exp_l[0] = 10'b0000000000;
        exp_l[1] = 10'b0000000001;
        exp_l[2] = 10'b0000000011;
        exp_l[3] = 10'b0000000111;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            state = 4'(i);
            step();
            n_checks++;
            if (panel !== exp_p[i]) begin
                n_fail++;
                $display("FAIL progress_segs[%0d]: got %b expected %b", i, panel, exp_p[i]);
            end
            n_checks++;
            if (leds_out !== exp_l[i]) begin
                n_fail++;
                $display("FAIL progress_leds[%0d]: got %b expected %b", i, leds_out, exp_l[i]);
            end
        end
    endtask

    task automatic test_done();
        state = 4'd4;
        step();
        n_checks++;
        if (panel !== P_DONE) begin
            n_fail++;
            $display("FAIL done_segs: got %b expected %b", panel, P_DONE);
        end
        n_checks++;
        if (leds_out !== 10'b1111111111) begin
            n_fail++;
            $display("FAIL done_leds: got %b expected %b", leds_out, 10'b1111111111);
        end
    endtask

    task automatic test_error_blink();
        logic [9:0] exp_l [10];
        exp_l = '{L_A, L_A, L_A, L_A, L_B, L_B, L_B, L_B, L_A, L_A};
        state = 4'd5;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                n_checks++;
                if (panel !== P_ERR) begin
                    n_fail++;
                    $display("FAIL error_segs: got %b expected %b", panel, P_ERR);
                end
            end
            n_checks++;
            if (leds_out !== exp_l[i]) begin
                n_fail++;
                $display("FAIL error_leds[%0d]: got %b expected %b", i, leds_out, exp_l[i]);
            end
        end
        // Leave while phase is B, then re-enter: must restart at A for a full period
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (leds_out !== L_B) begin
            n_fail++;
            $display("FAIL error_pre_exit: got %b expected %b", leds_out, L_B);
        end
        state = 4'd0;
        step();
        state = 4'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (leds_out !== ((i < 4) ? L_A : L_B)) begin
                n_fail++;
                $display("FAIL error_reentry[%0d]: got %b expected %b", i, leds_out,
                         ((i < 4) ? L_A : L_B));
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0] codes [2];
        codes = '{4'd6, 4'd15};
        for (int i = 0; i < 2; i++) begin
            state = codes[i];
            step();
            n_checks++;
            if (panel !== P_BLANK) begin
                n_fail++;
                $display("FAIL invalid_segs[%0d]: got %b expected %b", codes[i], panel, P_BLANK);
            end
            n_checks++;
            if (leds_out !== 10'b0) begin
                n_fail++;
                $display("FAIL invalid_leds[%0d]: got %b expected %b", codes[i], leds_out, 10'b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  seq   [6];
        logic [34:0] exp_p [6];
        logic [9:0]  exp_l [6];
        seq   = '{4'd2, 4'd4, 4'd5, 4'd7, 4'd5, 4'd3};
        exp_p = '{{G_P, G_DASH, G_DASH, G_UNDER, G_UNDER}, P_DONE, P_ERR, P_BLANK, P_ERR,
                  {G_P, G_DASH, G_DASH, G_DASH, G_UNDER}};
        exp_l = '{10'b0000000011, 10'b1111111111, L_A, 10'b0, L_A, 10'b0000000111};
        for (int i = 0; i < 6; i++) begin
            state = seq[i];
            step();
            n_checks++;
            if (panel !== exp_p[i] || leds_out !== exp_l[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %b/%b expected %b/%b", i, panel, leds_out,
                         exp_p[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_midrun_reset();
        state = 4'd5;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (leds_out !== L_B) begin
            n_fail++;
            $display("FAIL midrst_pre: got %b expected %b", leds_out, L_B);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (panel !== P_BLANK || leds_out !== 10'b0) begin
            n_fail++;
            $display("FAIL midrst_blank: got %b/%b expected %b/%b", panel, leds_out,
                     P_BLANK, 10'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (panel !== P_ERR || leds_out !== ((i < 4) ? L_A : L_B)) begin
                n_fail++;
                $display("FAIL midrst_restart[%0d]: got %b/%b expected %b/%b", i, panel,
                         leds_out, P_ERR, ((i < 4) ? L_A : L_B));
            end
        end
    endtask

    initial begin
        test_reset();
        test_progress();
        test_done();
        test_error_blink();
        test_invalid();
        test_back_to_back();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imprime.md
# imprime

Display driver for the password-lock front panel. It takes the lock FSM's 4-bit state code and drives five active-low seven-segment digits and a 10-LED bar:

- entry progress while digits are being typed;
- "OPEn" on success;
- "Error" with a blinking LED bar on failure.

All outputs are registered. The block sits directly after the password FSM and before the board pins.

## Interface
- BLINK_DIV, default 25_000_000: clock cycles per half-period of the error LED blink (0.5 s at 50 MHz).
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- state  in  4  lock FSM state code: 0 IDLE, 1 digit_2, 2 digit_3, 3 digit_4, 4 done, 5 error; 6–15 are invalid.
- leds_out  out  10  LED bar, active-high.
- seg0_out..seg4_out  out  7 each  digit drivers, active-low.
  - Bit order is {g,f,e,d,c,b,a}.
  - seg4 is the leftmost digit, seg0 the rightmost.

## Operation
Glyphs (active-low, {g..a}):
- blank 1111111, '-' 0111111, '_' 1110111
- 'P' 0001100, 'O' 1000000, 'E' 0000110
- 'n' 0101011, 'r' 0101111, 'o' 0100011

Per state, k = number of digits already entered (IDLE k=0, digit_2 k=1, digit_3 k=2, digit_4 k=3):
- IDLE/digit_2/digit_3/digit_4:
  - seg4 = 'P'.
  - seg3..seg0 each show '-' if already entered, else '_'. Digit position p (seg3 = position 0) counts as entered when p < k.
  - leds_out = thermometer with k ones in the LSBs.
- done: seg4..seg0 = 'O','P','E','n',blank; leds_out = 10'b1111111111.
- error:
  - seg4..seg0 = 'E','r','r','o','r'.
  - leds_out alternates 10'b1010101010 / 10'b0101010101, swapping every BLINK_DIV cycles.
  - Pattern starts at 1010101010 on the first error cycle.
- invalid codes 6–15: all segments blank (1111111), leds_out = 0.

Blink counter:
- Width is ceil(log2(BLINK_DIV)).
- Counts only while state==error.
- Cleared, together with the phase bit, on rst and on any cycle where state!=error.
- Re-entering error always restarts at 1010101010.

## Timing
- Reset (rst=1 at an edge): all seg outputs 1111111, leds_out 0, blink counter and phase 0. Reset dominates state.
- Latency: outputs reflect the state sampled at the previous rising edge (1 cycle). No combinational path from state to outputs.
- A state change every cycle must be tracked cycle-for-cycle; no filtering or hold.
- Blink:
  - Phase toggles on the edge where the counter reaches BLINK_DIV-1; the counter then wraps to 0.
  - The first toggle occurs BLINK_DIV cycles after the first registered error output.
- Deasserting rst mid-operation: the first post-reset edge registers the current state normally.

## Structure
- Package imprime_pkg:
  - state codes (ST_IDLE, ST_DIGIT2, ST_DIGIT3, ST_DIGIT4, ST_DONE, ST_ERROR);
  - 7-bit glyph constants;
  - LED pattern constants.
- Sub-module imprime_blink: parameterised BLINK_DIV counter with enable and clear, producing the phase bit.
- Top level holds the decode case statement and the output registers.

## Test plan
- Reset: hold rst=1 for 2 cycles with state=4 -> all segs 1111111, leds 0.
- Progress sweep: state 0,1,2,3, each held 1 cycle; one cycle later:
  - state 0: seg3..0 = '_','_','_','_'; leds 0000000000.
  - state 1: seg3='-', rest '_'; leds 0000000001.
  - state 2: seg3..2='-', seg1..0='_'; leds 0000000011.
  - state 3: seg3..1='-', seg0='_'; leds 0000000111.
  - seg4 = 0001100 throughout.
- done: state=4 -> segs 1000000, 0001100, 0000110, 0101011, 1111111; leds all ones.
- error blink (BLINK_DIV=4):
  - state=5 -> segs 'E','r','r','o','r'.
  - leds 1010101010 for 4 cycles, then 0101010101; leave error and re-enter -> 1010101010 again.
- Invalid: state=6, then 15 -> all blank, leds 0.
- Mid-run reset: rst pulsed for 1 cycle during error -> blank/off the next cycle, then error pattern restarts at 1010101010.
